// File: rtl/branch_sequencer_if.sv
// Handshake/bus bundle between the control unit (master) and branch_sequencer (slave).
interface branch_sequencer_if;
  logic        start;
  logic [31:0] ir;
  logic [31:0] pc;
  logic        con;
  logic        con_in;
  logic [31:0] pc_next;
  logic        pc_load;
  logic        taken;
  logic        illegal;
  logic        busy;
  logic        done;

  modport master (
    output start, ir, pc, con,
    input  con_in, pc_next, pc_load, taken, illegal, busy, done
  );

  modport slave (
    input  start, ir, pc, con,
    output con_in, pc_next, pc_load, taken, illegal, busy, done
  );
endinterface

// File: rtl/branch_sequencer.sv
// Multi-cycle conditional-branch sequencer: IDLE -> EVAL -> CALC -> LOAD -> DONE.
// Optional saturating taken/not-taken counters are enabled with `define BRANCH_STATS_EN.
module branch_sequencer #(
  parameter logic [4:0] BR_OPCODE = 5'b10010,
  parameter int         COUNT_W   = 16
) (
  input  logic               clk,
  input  logic               clr,
  branch_sequencer_if.slave  bus
`ifdef BRANCH_STATS_EN
  ,
  output logic [COUNT_W-1:0] taken_count,
  output logic [COUNT_W-1:0] not_taken_count
`endif
);

  typedef enum logic [2:0] {IDLE, EVAL, CALC, LOAD, DONE} state_t;

  state_t      state_reg, state_next;
  logic [4:0]  opcode_reg;
  logic [18:0] cfield_reg;
  logic [31:0] pc_reg;
  logic [31:0] pc_next_reg;
  logic        taken_reg;
  logic        illegal_reg;
  logic        legal;
  logic [31:0] offset;
  logic        con_in_next;
  logic        pc_load_next;
  logic        done_next;

  // Only the opcode and C-field are kept; the condition field is decoded by the CON FF.
  assign legal  = (opcode_reg == BR_OPCODE);
  assign offset = {{13{cfield_reg[18]}}, cfield_reg};

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    con_in_next  = 1'b0;
    pc_load_next = 1'b0;
    done_next    = 1'b0;
    case (state_reg)
      IDLE: if (bus.start) state_next = EVAL;
      EVAL: begin
        con_in_next = legal;
        state_next  = legal ? CALC : DONE;
      end
      CALC: state_next = LOAD;
      LOAD: begin
        pc_load_next = taken_reg;
        state_next   = DONE;
      end
      DONE: begin
        done_next  = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      opcode_reg  <= '0;
      cfield_reg  <= '0;
      pc_reg      <= '0;
      pc_next_reg <= '0;
      taken_reg   <= 1'b0;
      illegal_reg <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (bus.start) begin
          opcode_reg  <= bus.ir[31:27];
          cfield_reg  <= bus.ir[18:0];
          pc_reg      <= bus.pc;
          taken_reg   <= 1'b0;
          illegal_reg <= 1'b0;
        end
        EVAL: begin
          taken_reg   <= legal & bus.con;
          illegal_reg <= ~legal;
        end
        CALC: pc_next_reg <= pc_reg + offset;
        // A not-taken branch falls through to the already-incremented PC.
        LOAD: if (!taken_reg) pc_next_reg <= pc_reg;
        default: ;
      endcase
    end
  end

`ifdef BRANCH_STATS_EN
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      taken_count     <= '0;
      not_taken_count <= '0;
    end else if (state_reg == LOAD) begin
      if (taken_reg) begin
        if (taken_count != '1) taken_count <= taken_count + {{(COUNT_W-1){1'b0}}, 1'b1};
      end else begin
        if (not_taken_count != '1) not_taken_count <= not_taken_count + {{(COUNT_W-1){1'b0}}, 1'b1};
      end
    end
  end
`endif

  assign bus.con_in  = con_in_next;
  assign bus.pc_load = pc_load_next;
  assign bus.done    = done_next;
  assign bus.busy    = (state_reg != IDLE);
  assign bus.pc_next = pc_next_reg;
  assign bus.taken   = taken_reg;
  assign bus.illegal = illegal_reg;

endmodule

// File: tb/tb_branch_sequencer.sv
// Scoreboard bench for branch_sequencer: directed cases plus randomized branches vs a reference model.
module tb_branch_sequencer;

  logic clk = 1'b0;
  logic clr;
  always #5 clk = ~clk;

  branch_sequencer_if bus ();

`ifdef BRANCH_STATS_EN
  logic [1:0] taken_count, not_taken_count;
`endif

  branch_sequencer #(.BR_OPCODE(5'b10010), .COUNT_W(2)) dut (
    .clk (clk),
    .clr (clr),
    .bus (bus)
`ifdef BRANCH_STATS_EN
    ,
    .taken_count     (taken_count),
    .not_taken_count (not_taken_count)
`endif
  );

  typedef struct {
    logic        tk;
    logic        il;
    logic [31:0] pcn;
    int          lat;
  } exp_t;

  exp_t        expq[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] model_pcn = '0;
  int          model_tc  = 0;
  int          model_ntc = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: accumulates per-transaction observations and checks them when done pulses.
  int          mon_cyc = 0, mon_con = 0, mon_load = 0;
  logic [31:0] mon_load_val = '0;
  always @(negedge clk) begin
    if (clr) begin
      mon_cyc = 0; mon_con = 0; mon_load = 0;
    end else begin
      if (bus.busy)    mon_cyc++;
      if (bus.con_in)  mon_con++;
      if (bus.pc_load) begin mon_load++; mon_load_val = bus.pc_next; end
      if (bus.done) begin
        if (expq.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = expq.pop_front();
          chk("taken",    32'(bus.taken),   32'(e.tk));
          chk("illegal",  32'(bus.illegal), 32'(e.il));
          chk("pc_next",  bus.pc_next,      e.pcn);
          chk("latency",  32'(mon_cyc),     32'(e.lat));
          chk("con_in_n", 32'(mon_con),     32'(!e.il));
          chk("pc_load_n", 32'(mon_load),   32'(e.tk));
          if (e.tk) chk("load_val", mon_load_val, e.pcn);
        end
        mon_cyc = 0; mon_con = 0; mon_load = 0;
      end
    end
  end

  task automatic run_branch(input logic [31:0] i, input logic [31:0] p, input logic c, input bit poke);
    logic        lg;
    logic [18:0] cf;
    int          off;
    exp_t        e;
    lg  = (i[31:27] == 5'b10010);
    cf  = i[18:0];
    off = cf[18] ? int'(cf) - 524288 : int'(cf);
    e.tk  = lg && c;
    e.il  = !lg;
    e.pcn = !lg ? model_pcn : (e.tk ? p + 32'(off) : p);
    e.lat = lg ? 4 : 2;
    model_pcn = e.pcn;
    if (lg && e.tk)  model_tc  = (model_tc  < 3) ? model_tc + 1  : 3;
    if (lg && !e.tk) model_ntc = (model_ntc < 3) ? model_ntc + 1 : 3;
    expq.push_back(e);
    $display("txn ir=%h pc=%h con=%b poke=%0d -> taken=%b illegal=%b pc_next=%h",
             i, p, c, poke, e.tk, e.il, e.pcn);
    @(negedge clk);
    bus.start = 1'b1; bus.ir = i; bus.pc = p; bus.con = c;
    @(posedge clk);
    #1;
    bus.start = 1'b0; bus.ir = $urandom; bus.pc = $urandom;
    if (poke) begin
      @(negedge clk); bus.start = 1'b1;
      @(negedge clk); bus.start = 1'b0;
    end
    for (int k = 0; k < 20 && bus.busy; k++) @(negedge clk);
    if (bus.busy) chk("busy_timeout", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic [31:0] ri;
    clr = 1'b1; bus.start = 1'b0; bus.ir = '0; bus.pc = '0; bus.con = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy",    32'(bus.busy),    32'd0);
    chk("rst_pc_next", bus.pc_next,      32'd0);
    chk("rst_taken",   32'(bus.taken),   32'd0);
    chk("rst_done",    32'(bus.done),    32'd0);
    #1 clr = 1'b0;

    run_branch(32'h9000_0005, 32'h0000_0100, 1'b1, 1'b0);

    // Asynchronous clear while in EVAL: no completion, outputs back to zero.
    @(negedge clk);
    bus.start = 1'b1; bus.ir = 32'h9000_0040; bus.pc = 32'h0000_2000; bus.con = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    #2 clr = 1'b1;
    @(negedge clk);
    #1 clr = 1'b0;
    model_pcn = '0;
    @(negedge clk);
    chk("clr_busy",    32'(bus.busy),    32'd0);
    chk("clr_con_in",  32'(bus.con_in),  32'd0);
    chk("clr_pc_load", 32'(bus.pc_load), 32'd0);
    chk("clr_done",    32'(bus.done),    32'd0);
    chk("clr_pc_next", bus.pc_next,      32'd0);

    run_branch(32'h9007_FFFF, 32'h0000_0100, 1'b0, 1'b0);
    run_branch(32'h9000_0002, 32'hFFFF_FFFF, 1'b1, 1'b0);
    run_branch(32'h0000_0005, 32'h0000_0300, 1'b1, 1'b1);
    run_branch(32'h9004_0000, 32'h0000_0010, 1'b1, 1'b1);

    for (int n = 0; n < 30; n++) begin
      ri = $urandom;
      if ($urandom_range(3) != 0) ri[31:27] = 5'b10010;
      run_branch(ri, $urandom, 1'($urandom_range(1)), bit'($urandom_range(1)));
    end

    repeat (4) @(negedge clk);
    chk("queue_empty", 32'(expq.size()), 32'd0);
`ifdef BRANCH_STATS_EN
    chk("taken_count",     32'(taken_count),     32'(model_tc));
    chk("not_taken_count", 32'(not_taken_count), 32'(model_ntc));
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
